// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver: FSM state encoding,
// parity mode selectors and the parity check helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // data_xor is the XOR of all data bits; returns 1 when the received parity bit is wrong
  function automatic logic parity_bad(input logic data_xor, input logic par_bit, input int mode);
    logic ones_odd;
    ones_odd = data_xor ^ par_bit;
    return (mode == PAR_ODD) ? ~ones_odd : ones_odd;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered pointers and
// occupancy count; a write while full is only accepted alongside a pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   areset,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push, pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign pop     = rd_en & ~empty;
  assign push    = wr_en & (~full | pop);
  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Storage is cleared on reset so the head word reads as zero until the first write
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wr_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronises rx, frames start/data/parity/stop bits with a
// mid-bit sampling counter and pushes good words into a receive FIFO.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 106,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          areset,
  input  logic                          rx,
  output logic [DATA_BITS-1:0]          m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);

  logic                 rx_m_q, rx_s_q;
  rx_state_e            state_q;
  logic [CW-1:0]        cnt_q;
  logic [BW-1:0]        bit_q;
  logic                 stop_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic                 par_bad_q, stop_bad_q;
  logic                 frame_err_q, parity_err_q, overrun_q;
  logic                 last_stop, frame_bad, wr_en, pop, fifo_full, fifo_empty;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      rx_m_q <= 1'b1;
      rx_s_q <= 1'b1;
    end else begin
      rx_m_q <= rx;
      rx_s_q <= rx_m_q;
    end
  end

  // Final stop sample: decide the frame outcome and write in this same cycle
  assign last_stop = (state_q == ST_STOP) && (cnt_q == '0) && ((STOP_BITS == 1) || stop_q);
  assign frame_bad = stop_bad_q | ~rx_s_q;
  assign wr_en     = last_stop & ~frame_bad & ~par_bad_q;
  assign pop       = m_valid & m_ready;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      stop_q       <= 1'b0;
      shreg_q      <= '0;
      par_bad_q    <= 1'b0;
      stop_bad_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= wr_en & fifo_full & ~pop;
      case (state_q)
        ST_IDLE: begin
          if (!rx_s_q) begin
            state_q <= ST_START;
            cnt_q   <= CW'(CLKS_PER_BIT/2 - 1);
          end
        end
        ST_START: begin
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
          else if (rx_s_q) state_q <= ST_IDLE;
          else begin
            state_q    <= ST_DATA;
            cnt_q      <= CW'(CLKS_PER_BIT - 1);
            bit_q      <= '0;
            stop_q     <= 1'b0;
            par_bad_q  <= 1'b0;
            stop_bad_q <= 1'b0;
          end
        end
        ST_DATA: begin
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
          else begin
            shreg_q <= {rx_s_q, shreg_q[DATA_BITS-1:1]};
            cnt_q   <= CW'(CLKS_PER_BIT - 1);
            if (bit_q == BW'(DATA_BITS - 1))
              state_q <= (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
            else
              bit_q <= bit_q + 1'b1;
          end
        end
        ST_PARITY: begin
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
          else begin
            par_bad_q <= parity_bad(^shreg_q, rx_s_q, PARITY);
            cnt_q     <= CW'(CLKS_PER_BIT - 1);
            state_q   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
          else if (last_stop) begin
            state_q      <= ST_IDLE;
            frame_err_q  <= frame_bad;
            parity_err_q <= ~frame_bad & par_bad_q;
          end else begin
            stop_q     <= 1'b1;
            stop_bad_q <= ~rx_s_q;
            cnt_q      <= CW'(CLKS_PER_BIT - 1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .areset (areset),
    .wr_en  (wr_en),
    .wr_data(shreg_q),
    .rd_en  (m_ready),
    .rd_data(m_data),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign m_valid    = ~fifo_empty;
  assign busy       = (state_q != ST_IDLE);
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 106, clk cycles per serial bit (min 8).
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame (5..9).
REQ-003 SHALL have parameter PARITY, default 0, parity mode (0 none, 1 odd, 2 even).
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits checked (1 or 2).
REQ-005 SHALL have parameter FIFO_DEPTH, default 16, receive FIFO entries (power of two, >=2).
REQ-006 SHALL have clk  input  1  design clock; one clock domain only.
REQ-007 SHALL have areset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have rx  input  1  asynchronous serial line, idle high.
REQ-009 SHALL have m_data  output  DATA_BITS  FIFO head word.
REQ-010 SHALL have m_valid  output  1  FIFO non-empty.
REQ-011 SHALL have m_ready  input  1  consumer accepts head word.
REQ-012 SHALL have fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy.
REQ-013 SHALL have busy  output  1  FSM not in IDLE.
REQ-014 SHALL have frame_err, parity_err, overrun  output  1 each  single-cycle error pulses.

Function
REQ-015 SHALL pass rx through a 2-flop synchroniser (reset value 1); all logic uses the synchronised rx_s.
REQ-016 SHALL implement FSM IDLE, START, DATA, PARITY, STOP, with PARITY skipped when PARITY=0.
REQ-017 IDLE->START SHALL occur on the first cycle rx_s is 0; the bit counter then loads CLKS_PER_BIT/2-1.
REQ-018 At START mid-bit, rx_s=1 SHALL count as a false start: return to IDLE with no pulse and no write.
REQ-019 After a valid start, each later bit SHALL be sampled exactly CLKS_PER_BIT cycles after the previous sample.
REQ-020 Data SHALL be shifted in LSB first; m_data[0] is the first data bit.
REQ-021 Parity SHALL be checked against the XOR of the data bits: odd mode requires the total ones count incl. parity bit to be odd, even mode requires it to be even.
REQ-022 Each stop bit SHALL be sampled; any 0 SHALL flag a framing error.
REQ-023 At the final stop sample, the FSM SHALL return to IDLE in the same cycle, so a start edge is detectable half a bit early.
REQ-024 At the final stop sample, a frame error SHALL pulse frame_err and discard the word.
REQ-025 Otherwise, a parity error SHALL pulse parity_err and discard the word; frame_err has priority, one pulse per frame.
REQ-026 A good word SHALL be written to the FIFO in the final stop-sample cycle; m_valid SHALL rise on the next cycle if the FIFO was empty.
REQ-027 A pop SHALL occur when m_valid and m_ready are both 1 on a rising clk edge; m_data SHALL show the next word on the following cycle (first-word fall-through).
REQ-028 A write while full with no pop that cycle SHALL drop the new word and pulse overrun; stored data is unchanged.
REQ-029 A write while full with a simultaneous pop SHALL be accepted, with no overrun.
REQ-030 Simultaneous write and pop at any occupancy SHALL leave fifo_count unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-031 m_data SHALL hold its value while m_valid=0; consumers ignore it.

Reset
REQ-032 areset SHALL force, asynchronously: FSM=IDLE, synchroniser=1, counters=0, FIFO empty, m_valid=0, fifo_count=0, busy=0, all error pulses 0, m_data=0.
REQ-033 areset mid-frame SHALL abandon the frame with no write and no error pulse; the first falling edge after release starts a new frame.

Structure
REQ-034 A shared package uart_pkg SHALL hold the FSM state enum and the parity mode constants (PAR_NONE, PAR_ODD, PAR_EVEN).
REQ-035 The FIFO SHALL be a separate sub-module sync_fifo, parametrised by WIDTH and DEPTH, with registered pointers and a count output.

Verification
REQ-036 CLKS_PER_BIT=16, 8N1, send 0x55 -> m_valid 1 cycle after the stop mid-sample; m_data=0x55; no error pulse.
REQ-037 PARITY=2, send 0xA3 with parity bit 1 -> parity_err pulses once; FIFO stays empty. With parity bit 0 -> word 0xA3 is accepted.
REQ-038 8N1, send 0x41 with the stop bit driven 0 -> frame_err pulses once; no write; the next frame 0x42 is received correctly.
REQ-039 Glitch: rx low for 5 cycles (<8) -> no busy beyond the START mid-sample, no write, no pulse.
REQ-040 FIFO_DEPTH=4, m_ready=0, send 5 bytes 0x01..0x05 -> fifo_count=4, overrun pulses on byte 5; draining returns 0x01..0x04.
REQ-041 Assert areset during data bit 3 of a frame -> all outputs reset; a frame 0x7E sent after release is received intact.
